// File: rtl/hls_monitor_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
// FSM state encoding, cause-type constants and a width helper.
package hls_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUSPECT,
        DEADLOCK
    } monitor_state_e;

    localparam logic CAUSE_AXIS = 1'b0;
    localparam logic CAUSE_INST = 1'b1;

    // Ceiling log2, never less than 1 so derived vectors stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/hls_monitor_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any bit is set
// and the index of the lowest set bit.
module hls_monitor_prio_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] bits,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!valid && bits[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS dataflow region: filters transient back-pressure
// with a persistence threshold and holds a sticky deadlock with first-cause capture.
module hls_deadlock_monitor_param
    import hls_monitor_pkg::*;
#(
    parameter int NUM_AXIS  = 3,
    parameter int NUM_INST  = 4,
    parameter int THRESHOLD = 16,
    parameter int STALL_W   = 16,
    parameter int IDX_W     = clog2((NUM_AXIS > NUM_INST) ? NUM_AXIS : NUM_INST)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic                block,
    output logic                deadlock,
    output logic                cause_valid,
    output logic                cause_type,
    output logic [IDX_W-1:0]    cause_idx,
    output logic [STALL_W-1:0]  stall_cycles
);

    localparam int CNT_W = clog2(THRESHOLD + 1);

    monitor_state_e     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               block_q;
    logic               cause_valid_q, cause_valid_d;
    logic               cause_type_q, cause_type_d;
    logic [IDX_W-1:0]   cause_idx_q, cause_idx_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [NUM_INST-1:0] inst_qual;
    logic                axis_valid, inst_valid, cand;
    logic [IDX_W-1:0]    axis_idx, inst_idx;

    // An instance that is idle cannot be the one holding the region up.
    assign inst_qual = inst_block_sigs & ~inst_idle_sigs;
    assign cand      = axis_valid | inst_valid;

    hls_monitor_prio_enc #(
        .WIDTH (NUM_AXIS),
        .IDX_W (IDX_W)
    ) u_axis_enc (
        .bits  (axis_block_sigs),
        .valid (axis_valid),
        .idx   (axis_idx)
    );

    hls_monitor_prio_enc #(
        .WIDTH (NUM_INST),
        .IDX_W (IDX_W)
    ) u_inst_enc (
        .bits  (inst_qual),
        .valid (inst_valid),
        .idx   (inst_idx)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cause_valid_d = cause_valid_q;
        cause_type_d  = cause_type_q;
        cause_idx_d   = cause_idx_q;
        stall_d       = stall_q;

        if (clear) begin
            state_d       = IDLE;
            cnt_d         = '0;
            cause_valid_d = 1'b0;
            cause_type_d  = CAUSE_AXIS;
            cause_idx_d   = '0;
            stall_d       = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cand) begin
                        cause_valid_d = 1'b1;
                        cause_type_d  = axis_valid ? CAUSE_AXIS : CAUSE_INST;
                        cause_idx_d   = axis_valid ? axis_idx : inst_idx;
                        if (THRESHOLD == 1) begin
                            state_d = DEADLOCK;
                        end else begin
                            state_d = SUSPECT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                SUSPECT: begin
                    if (!cand) begin
                        state_d       = IDLE;
                        cnt_d         = '0;
                        cause_valid_d = 1'b0;
                    end else if (cnt_q == CNT_W'(THRESHOLD - 1)) begin
                        state_d = DEADLOCK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DEADLOCK: begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            block_q       <= 1'b0;
            cause_valid_q <= 1'b0;
            cause_type_q  <= CAUSE_AXIS;
            cause_idx_q   <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            block_q       <= cand;
            cause_valid_q <= cause_valid_d;
            cause_type_q  <= cause_type_d;
            cause_idx_q   <= cause_idx_d;
            stall_q       <= stall_d;
        end
    end

    assign block        = block_q;
    assign deadlock     = (state_q == DEADLOCK);
    assign cause_valid  = cause_valid_q;
    assign cause_type   = cause_type_q;
    assign cause_idx    = cause_idx_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Directed scoreboard bench for hls_deadlock_monitor_param (THRESHOLD=4),
// with a narrow-counter twin instance for stall saturation.
module tb_hls_deadlock_monitor_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [2:0] axis_block_sigs = '0;
    logic [3:0] inst_idle_sigs  = '0;
    logic [3:0] inst_block_sigs = '0;

    logic        block, deadlock, cause_valid, cause_type;
    logic [1:0]  cause_idx;
    logic [15:0] stall_cycles;

    logic        block_s, deadlock_s, cause_valid_s, cause_type_s;
    logic [1:0]  cause_idx_s;
    logic [3:0]  stall_cycles_s;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    typedef struct {
        string tag;
        bit    b;
        bit    d;
        bit    cv;
        int    ct;
        int    ci;
        int    st;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    hls_deadlock_monitor_param #(
        .NUM_AXIS  (3),
        .NUM_INST  (4),
        .THRESHOLD (4),
        .STALL_W   (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .clear           (clear),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block),
        .deadlock        (deadlock),
        .cause_valid     (cause_valid),
        .cause_type      (cause_type),
        .cause_idx       (cause_idx),
        .stall_cycles    (stall_cycles)
    );

    hls_deadlock_monitor_param #(
        .NUM_AXIS  (3),
        .NUM_INST  (4),
        .THRESHOLD (4),
        .STALL_W   (4)
    ) dut_s (
        .clock           (clock),
        .reset           (reset),
        .clear           (clear),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block_s),
        .deadlock        (deadlock_s),
        .cause_valid     (cause_valid_s),
        .cause_type      (cause_type_s),
        .cause_idx       (cause_idx_s),
        .stall_cycles    (stall_cycles_s)
    );

    task automatic chk(input string tag, input string field, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue expectation, sample #1 after the edge.
    task automatic cyc(input string tag, input logic [2:0] a, input logic [3:0] ib,
                       input logic [3:0] ii, input bit clr, input bit rst,
                       input bit eb, input bit ed, input bit ecv,
                       input int ect, input int eci, input int est);
        exp_t e;
        axis_block_sigs = a;
        inst_block_sigs = ib;
        inst_idle_sigs  = ii;
        clear           = clr;
        reset           = rst;
        e.tag = tag; e.b = eb; e.d = ed; e.cv = ecv; e.ct = ect; e.ci = eci; e.st = est;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk(e.tag, "block", 32'(block), 32'(e.b));
        chk(e.tag, "deadlock", 32'(deadlock), 32'(e.d));
        chk(e.tag, "cause_valid", 32'(cause_valid), 32'(e.cv));
        if (e.ct >= 0) chk(e.tag, "cause_type", 32'(cause_type), 32'(e.ct));
        if (e.ci >= 0) chk(e.tag, "cause_idx", 32'(cause_idx), 32'(e.ci));
        if (e.st >= 0) begin
            chk(e.tag, "stall", 32'(stall_cycles), 32'(e.st));
            chk(e.tag, "stall4", 32'(stall_cycles_s), 32'((e.st > 15) ? 15 : e.st));
            chk(e.tag, "deadlock4", 32'(deadlock_s), 32'(e.d));
        end
    endtask

    initial begin
        #1;
        cyc("reset", 3'b000, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("reset2", 3'b111, 4'hF, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Transient back-pressure never reaches the threshold.
        for (int i = 0; i < 3; i++)
            cyc("transient", 3'b010, 4'h0, 4'h0, 0, 0, 1, 0, 1, 0, 1, 0);
        cyc("trans_rel", 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0, -1, -1, 0);
        cyc("trans_idle", 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0, -1, -1, 0);

        // Persistent axis block: deadlock after the 4th edge.
        for (int i = 0; i < 3; i++)
            cyc("persist", 3'b110, 4'h0, 4'h0, 0, 0, 1, 0, 1, 0, 1, 0);
        cyc("persist_dl", 3'b110, 4'h0, 4'h0, 0, 0, 1, 1, 1, 0, 1, 0);
        for (int i = 1; i <= 5; i++)
            cyc("persist_stall", 3'b110, 4'h0, 4'h0, 0, 0, 1, 1, 1, 0, 1, i);

        // Sticky with inputs dropped, then clear.
        cyc("sticky", 3'b000, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0, 1, 6);
        cyc("clear", 3'b000, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("post_clear", 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Idle-masked instance: only instance 3 qualifies.
        for (int i = 0; i < 3; i++)
            cyc("inst", 3'b000, 4'b1010, 4'b0010, 0, 0, 1, 0, 1, 1, 3, 0);
        cyc("inst_dl", 3'b000, 4'b1010, 4'b0010, 0, 0, 1, 1, 1, 1, 3, 0);
        cyc("inst_masked", 3'b000, 4'b0010, 4'b0010, 0, 0, 0, 1, 1, 1, 3, 1);
        cyc("inst_clear", 3'b000, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("all_masked", 3'b000, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0);

        // Clear concurrent with cand: detection restarts the next edge.
        cyc("clr_cand", 3'b001, 4'h0, 4'h0, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("clr_restart", 3'b001, 4'h0, 4'h0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc("clr_dl", 3'b001, 4'h0, 4'h0, 0, 0, 1, 1, 1, 0, 0, 0);

        // Saturation of the 4-bit twin while the 16-bit counter keeps going.
        for (int i = 1; i <= 20; i++)
            cyc("saturate", 3'b001, 4'h0, 4'h0, 0, 0, 1, 1, 1, 0, 0, i);

        cyc("mid_reset", 3'b001, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mid_reset", "cause_valid4", 32'(cause_valid_s), 32'd0);
        chk("mid_reset", "block4", 32'(block_s), 32'd0);
        cyc("after_reset", 3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
